// File: rtl/clock_alarm_pkg.sv
// Shared types and digit constants for the alarm clock blocks.
package clock_alarm_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZE   = 2'd3
  } alarm_state_t;

  // BCD digit widths: hours tens/units, minutes tens/units
  localparam int HT_W = 2;
  localparam int HU_W = 4;
  localparam int MT_W = 3;
  localparam int MU_W = 4;

  // Highest hour in 24-hour format and highest minutes tens digit
  localparam int MAX_H  = 23;
  localparam int MAX_MT = 5;

endpackage : clock_alarm_pkg

// File: rtl/alarm_time_register.sv
// Alarm time storage: four BCD digits (HH:MM) with minute/hour increment
// and wrap rules. Minutes never carry into hours.
module alarm_time_register
  import clock_alarm_pkg::*;
(
  input  logic            clk,
  input  logic            reset,        // synchronous, active-low
  input  logic            set_alarm_i,
  input  logic            min_inc_i,
  input  logic            hr_inc_i,
  output logic [HT_W-1:0] al_h_t_o,
  output logic [HU_W-1:0] al_h_u_o,
  output logic [MT_W-1:0] al_m_t_o,
  output logic [MU_W-1:0] al_m_u_o
);

  localparam logic [HT_W-1:0] H_T_MAX  = HT_W'(MAX_H / 10);
  localparam logic [HU_W-1:0] H_U_MAX  = HU_W'(MAX_H % 10);
  localparam logic [MT_W-1:0] M_T_MAX  = MT_W'(MAX_MT);
  localparam logic [HU_W-1:0] DIGIT_9H = HU_W'(9);
  localparam logic [MU_W-1:0] DIGIT_9M = MU_W'(9);

  logic [HT_W-1:0] h_t_q, h_t_d;
  logic [HU_W-1:0] h_u_q, h_u_d;
  logic [MT_W-1:0] m_t_q, m_t_d;
  logic [MU_W-1:0] m_u_q, m_u_d;

  // Next-state digits; minute and hour edits are independent so both apply together
  always_comb begin
    h_t_d = h_t_q;
    h_u_d = h_u_q;
    m_t_d = m_t_q;
    m_u_d = m_u_q;

    if (set_alarm_i && min_inc_i) begin
      if (m_u_q >= DIGIT_9M) begin
        m_u_d = '0;
        m_t_d = (m_t_q >= M_T_MAX) ? '0 : m_t_q + 1'b1;
      end else begin
        m_u_d = m_u_q + 1'b1;
      end
    end

    if (set_alarm_i && hr_inc_i) begin
      if (h_t_q == H_T_MAX && h_u_q >= H_U_MAX) begin
        h_t_d = '0;
        h_u_d = '0;
      end else if (h_u_q >= DIGIT_9H) begin
        h_u_d = '0;
        h_t_d = h_t_q + 1'b1;
      end else begin
        h_u_d = h_u_q + 1'b1;
      end
    end
  end

  // Digit registers, cleared to 00:00 on reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      h_t_q <= '0;
      h_u_q <= '0;
      m_t_q <= '0;
      m_u_q <= '0;
    end else begin
      h_t_q <= h_t_d;
      h_u_q <= h_u_d;
      m_t_q <= m_t_d;
      m_u_q <= m_u_d;
    end
  end

  assign al_h_t_o = h_t_q;
  assign al_h_u_o = h_u_q;
  assign al_m_t_o = m_t_q;
  assign al_m_u_o = m_u_q;

endmodule : alarm_time_register

// File: rtl/alarm_controller.sv
// Alarm controller: compares running time against the stored alarm time and
// runs the DISABLED/ARMED/RINGING/SNOOZE state machine driving the buzzer.
module alarm_controller
  import clock_alarm_pkg::*;
#(
  parameter int RING_TICKS   = 60,
  parameter int SNOOZE_TICKS = 300,
  parameter int CNT_W = $clog2(((RING_TICKS > SNOOZE_TICKS) ? RING_TICKS : SNOOZE_TICKS) + 1)
) (
  input  logic            clk,
  input  logic            reset,        // synchronous, active-low
  input  logic            tick,
  input  logic [HT_W-1:0] time_h_t,
  input  logic [HU_W-1:0] time_h_u,
  input  logic [MT_W-1:0] time_m_t,
  input  logic [MU_W-1:0] time_m_u,
  input  logic [2:0]      time_s_t,
  input  logic [3:0]      time_s_u,
  input  logic            alarm_en,
  input  logic            set_alarm,
  input  logic            min_inc,
  input  logic            hr_inc,
  input  logic            alarm_off,
  input  logic            snooze,
  output logic            alarm_out,
  output logic            alarm_active,
  output logic [HT_W-1:0] al_h_t,
  output logic [HU_W-1:0] al_h_u,
  output logic [MT_W-1:0] al_m_t,
  output logic [MU_W-1:0] al_m_u,
  output logic [1:0]      state
);

  localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_TICKS);
  localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(1);

  alarm_state_t     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             alarm_out_q;
  logic             alarm_active_q;
  logic             match;

  alarm_time_register u_time_reg (
    .clk         (clk),
    .reset       (reset),
    .set_alarm_i (set_alarm),
    .min_inc_i   (min_inc),
    .hr_inc_i    (hr_inc),
    .al_h_t_o    (al_h_t),
    .al_h_u_o    (al_h_u),
    .al_m_t_o    (al_m_t),
    .al_m_u_o    (al_m_u)
  );

  // Trigger only on a tick at second 00 so one alarm minute fires once
  always_comb begin
    match = tick && (state_q == ARMED) && !set_alarm &&
            (time_h_t == al_h_t) && (time_h_u == al_h_u) &&
            (time_m_t == al_m_t) && (time_m_u == al_m_u) &&
            (time_s_t == 3'd0) && (time_s_u == 4'd0);
  end

  // Alarm FSM with shared tick down-counter and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= DISABLED;
      cnt_q          <= '0;
      alarm_out_q    <= 1'b0;
      alarm_active_q <= 1'b0;
    end else if (!alarm_en) begin
      state_q        <= DISABLED;
      cnt_q          <= '0;
      alarm_out_q    <= 1'b0;
      alarm_active_q <= 1'b0;
    end else begin
      case (state_q)
        DISABLED: begin
          state_q        <= ARMED;
          cnt_q          <= '0;
          alarm_out_q    <= 1'b0;
          alarm_active_q <= 1'b0;
        end
        ARMED: begin
          if (match) begin
            state_q        <= RINGING;
            cnt_q          <= RING_LOAD;
            alarm_out_q    <= 1'b1;
            alarm_active_q <= 1'b1;
          end
        end
        RINGING: begin
          if (set_alarm || alarm_off) begin
            state_q        <= ARMED;
            cnt_q          <= '0;
            alarm_out_q    <= 1'b0;
            alarm_active_q <= 1'b0;
          end else if (snooze) begin
            state_q        <= SNOOZE;
            cnt_q          <= SNOOZE_LOAD;
            alarm_out_q    <= 1'b0;
            alarm_active_q <= 1'b1;
          end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
              state_q        <= ARMED;
              cnt_q          <= '0;
              alarm_out_q    <= 1'b0;
              alarm_active_q <= 1'b0;
            end else begin
              cnt_q       <= cnt_q - 1'b1;
              alarm_out_q <= ~alarm_out_q;
            end
          end
        end
        SNOOZE: begin
          // Further snooze pulses are deliberately ignored here
          if (set_alarm || alarm_off) begin
            state_q        <= ARMED;
            cnt_q          <= '0;
            alarm_out_q    <= 1'b0;
            alarm_active_q <= 1'b0;
          end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
              state_q        <= RINGING;
              cnt_q          <= RING_LOAD;
              alarm_out_q    <= 1'b1;
              alarm_active_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        default: begin
          state_q        <= DISABLED;
          cnt_q          <= '0;
          alarm_out_q    <= 1'b0;
          alarm_active_q <= 1'b0;
        end
      endcase
    end
  end

  assign alarm_out    = alarm_out_q;
  assign alarm_active = alarm_active_q;
  assign state        = state_q;

endmodule : alarm_controller

// File: tb/tb_alarm_controller.sv
// Directed testbench for alarm_controller.
module tb_alarm_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [1:0] time_h_t;
  logic [3:0] time_h_u;
  logic [2:0] time_m_t;
  logic [3:0] time_m_u;
  logic [2:0] time_s_t;
  logic [3:0] time_s_u;
  logic       alarm_en;
  logic       set_alarm;
  logic       min_inc;
  logic       hr_inc;
  logic       alarm_off;
  logic       snooze;
  logic       alarm_out;
  logic       alarm_active;
  logic [1:0] al_h_t;
  logic [3:0] al_h_u;
  logic [2:0] al_m_t;
  logic [3:0] al_m_u;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] S_DIS = 2'd0;
  localparam logic [1:0] S_ARM = 2'd1;
  localparam logic [1:0] S_RNG = 2'd2;
  localparam logic [1:0] S_SNZ = 2'd3;

  always #5 clk = ~clk;

  alarm_controller dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .time_h_t     (time_h_t),
    .time_h_u     (time_h_u),
    .time_m_t     (time_m_t),
    .time_m_u     (time_m_u),
    .time_s_t     (time_s_t),
    .time_s_u     (time_s_u),
    .alarm_en     (alarm_en),
    .set_alarm    (set_alarm),
    .min_inc      (min_inc),
    .hr_inc       (hr_inc),
    .alarm_off    (alarm_off),
    .snooze       (snooze),
    .alarm_out    (alarm_out),
    .alarm_active (alarm_active),
    .al_h_t       (al_h_t),
    .al_h_u       (al_h_u),
    .al_m_t       (al_m_t),
    .al_m_u       (al_m_u),
    .state        (state)
  );

  // Alarm digits packed as a 16-bit HHMM BCD word for easy comparison
  function automatic logic [15:0] al_word();
    return {2'b00, al_h_t, al_h_u, 1'b0, al_m_t, al_m_u};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input logic [1:0] ht, input logic [3:0] hu,
                          input logic [2:0] mt, input logic [3:0] mu,
                          input logic [2:0] st, input logic [3:0] su);
    time_h_t = ht; time_h_u = hu; time_m_t = mt;
    time_m_u = mu; time_s_t = st; time_s_u = su;
  endtask

  task automatic pulse_min(input int n);
    for (int i = 0; i < n; i++) begin
      min_inc = 1'b1; step(); min_inc = 1'b0;
    end
  endtask

  task automatic pulse_hr(input int n);
    for (int i = 0; i < n; i++) begin
      hr_inc = 1'b1; step(); hr_inc = 1'b0;
    end
  endtask

  task automatic do_tick();
    tick = 1'b1; step(); tick = 1'b0; step();
  endtask

  // Present 07:30:00 on one tick, then move the clock away from the alarm time
  task automatic fire_match();
    set_time(2'd0, 4'd7, 3'd3, 4'd0, 3'd0, 4'd0);
    tick = 1'b1; step(); tick = 1'b0;
    set_time(2'd1, 4'd2, 3'd0, 4'd0, 3'd0, 4'd0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(); step();
    total++; if (state !== S_DIS) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", state, S_DIS); end
    total++; if (alarm_out !== 1'b0 || alarm_active !== 1'b0) begin bad++; $display("FAIL reset_outs got=%b%b exp=00", alarm_out, alarm_active); end
    total++; if (al_word() !== 16'h0000) begin bad++; $display("FAIL reset_digits got=%h exp=0000", al_word()); end
    reset = 1'b1;
    step();
    $display("reset: state=%0d alarm=%h", state, al_word());
  endtask

  task automatic test_setting();
    // increments ignored while not editing
    pulse_min(1); pulse_hr(1);
    total++; if (al_word() !== 16'h0000) begin bad++; $display("FAIL edit_locked got=%h exp=0000", al_word()); end
    set_alarm = 1'b1;
    pulse_hr(7);
    pulse_min(30);
    total++; if (al_word() !== 16'h0730) begin bad++; $display("FAIL set_0730 got=%h exp=0730", al_word()); end
    total++; if (state !== S_DIS || alarm_out !== 1'b0) begin bad++; $display("FAIL set_state got=%0d/%b exp=0/0", state, alarm_out); end
    $display("setting: alarm=%h state=%0d", al_word(), state);
  endtask

  task automatic test_wrap();
    pulse_hr(16);
    pulse_min(29);
    total++; if (al_word() !== 16'h2359) begin bad++; $display("FAIL wrap_2359 got=%h exp=2359", al_word()); end
    pulse_min(1);
    total++; if (al_word() !== 16'h2300) begin bad++; $display("FAIL wrap_min got=%h exp=2300", al_word()); end
    pulse_hr(1);
    total++; if (al_word() !== 16'h0000) begin bad++; $display("FAIL wrap_hr got=%h exp=0000", al_word()); end
    pulse_hr(9);
    total++; if (al_word() !== 16'h0900) begin bad++; $display("FAIL hr_09 got=%h exp=0900", al_word()); end
    pulse_hr(1);
    total++; if (al_word() !== 16'h1000) begin bad++; $display("FAIL hr_10 got=%h exp=1000", al_word()); end
    pulse_hr(9); pulse_min(9);
    total++; if (al_word() !== 16'h1909) begin bad++; $display("FAIL hr_19 got=%h exp=1909", al_word()); end
    // simultaneous edits: 19:09 -> 20:10
    min_inc = 1'b1; hr_inc = 1'b1; step(); min_inc = 1'b0; hr_inc = 1'b0;
    total++; if (al_word() !== 16'h2010) begin bad++; $display("FAIL both_inc got=%h exp=2010", al_word()); end
    // back to 07:30: 20 -> 07 is 11 hours, 10 -> 30 is 20 minutes
    pulse_hr(11); pulse_min(20);
    total++; if (al_word() !== 16'h0730) begin bad++; $display("FAIL reset_0730 got=%h exp=0730", al_word()); end
    set_alarm = 1'b0;
    step();
    $display("wrap: alarm=%h", al_word());
  endtask

  task automatic test_trigger();
    alarm_en = 1'b1; step();
    total++; if (state !== S_ARM) begin bad++; $display("FAIL arm got=%0d exp=%0d", state, S_ARM); end
    set_time(2'd0, 4'd7, 3'd2, 4'd9, 3'd5, 4'd9);
    do_tick();
    total++; if (state !== S_ARM) begin bad++; $display("FAIL early got=%0d exp=%0d", state, S_ARM); end
    fire_match();
    total++; if (state !== S_RNG || alarm_out !== 1'b1 || alarm_active !== 1'b1) begin bad++; $display("FAIL ring_entry got=%0d/%b/%b exp=2/1/1", state, alarm_out, alarm_active); end
    for (int k = 1; k <= 59; k++) begin
      do_tick();
      total++; if (alarm_out !== ((k % 2) == 0)) begin bad++; $display("FAIL beep_%0d got=%b exp=%b", k, alarm_out, ((k % 2) == 0)); end
    end
    total++; if (state !== S_RNG) begin bad++; $display("FAIL ring_59 got=%0d exp=%0d", state, S_RNG); end
    do_tick();
    total++; if (state !== S_ARM || alarm_out !== 1'b0 || alarm_active !== 1'b0) begin bad++; $display("FAIL ring_timeout got=%0d/%b/%b exp=1/0/0", state, alarm_out, alarm_active); end
    set_time(2'd0, 4'd7, 3'd3, 4'd0, 3'd0, 4'd1);
    do_tick();
    total++; if (state !== S_ARM) begin bad++; $display("FAIL retrigger got=%0d exp=%0d", state, S_ARM); end
    $display("trigger: state=%0d out=%b", state, alarm_out);
  endtask

  task automatic test_snooze();
    fire_match();
    total++; if (state !== S_RNG) begin bad++; $display("FAIL snz_ring got=%0d exp=%0d", state, S_RNG); end
    snooze = 1'b1; step(); snooze = 1'b0;
    total++; if (state !== S_SNZ || alarm_out !== 1'b0 || alarm_active !== 1'b1) begin bad++; $display("FAIL snz_entry got=%0d/%b/%b exp=3/0/1", state, alarm_out, alarm_active); end
    do_tick();
    // a second snooze must neither leave SNOOZE nor reload the counter
    snooze = 1'b1; step(); snooze = 1'b0;
    total++; if (state !== S_SNZ) begin bad++; $display("FAIL snz_ignore got=%0d exp=%0d", state, S_SNZ); end
    for (int k = 2; k <= 299; k++) do_tick();
    total++; if (state !== S_SNZ || alarm_out !== 1'b0) begin bad++; $display("FAIL snz_299 got=%0d/%b exp=3/0", state, alarm_out); end
    do_tick();
    total++; if (state !== S_RNG || alarm_out !== 1'b1) begin bad++; $display("FAIL snz_expire got=%0d/%b exp=2/1", state, alarm_out); end
    alarm_off = 1'b1; step(); alarm_off = 1'b0;
    total++; if (state !== S_ARM || alarm_out !== 1'b0 || alarm_active !== 1'b0) begin bad++; $display("FAIL off got=%0d/%b/%b exp=1/0/0", state, alarm_out, alarm_active); end
    $display("snooze: state=%0d out=%b", state, alarm_out);
  endtask

  task automatic test_priority();
    fire_match();
    alarm_off = 1'b1; snooze = 1'b1; step(); alarm_off = 1'b0; snooze = 1'b0;
    total++; if (state !== S_ARM) begin bad++; $display("FAIL off_over_snz got=%0d exp=%0d", state, S_ARM); end
    fire_match();
    set_alarm = 1'b1; step(); set_alarm = 1'b0;
    total++; if (state !== S_ARM || alarm_out !== 1'b0) begin bad++; $display("FAIL set_in_ring got=%0d/%b exp=1/0", state, alarm_out); end
    // editing suppresses the match
    set_alarm = 1'b1; fire_match(); set_alarm = 1'b0;
    total++; if (state !== S_ARM) begin bad++; $display("FAIL edit_nomatch got=%0d exp=%0d", state, S_ARM); end
    fire_match();
    snooze = 1'b1; step(); snooze = 1'b0;
    alarm_en = 1'b0; step();
    total++; if (state !== S_DIS || alarm_active !== 1'b0) begin bad++; $display("FAIL en_off got=%0d/%b exp=0/0", state, alarm_active); end
    fire_match(); step();
    total++; if (state !== S_DIS || alarm_out !== 1'b0) begin bad++; $display("FAIL dis_nomatch got=%0d/%b exp=0/0", state, alarm_out); end
    $display("priority: state=%0d", state);
  endtask

  task automatic test_reset_mid_ring();
    alarm_en = 1'b1; step();
    fire_match();
    total++; if (state !== S_RNG) begin bad++; $display("FAIL mid_ring got=%0d exp=%0d", state, S_RNG); end
    reset = 1'b0; step();
    total++; if (state !== S_DIS || alarm_out !== 1'b0 || alarm_active !== 1'b0) begin bad++; $display("FAIL mid_reset got=%0d/%b/%b exp=0/0/0", state, alarm_out, alarm_active); end
    total++; if (al_word() !== 16'h0000) begin bad++; $display("FAIL mid_digits got=%h exp=0000", al_word()); end
    reset = 1'b1; step();
    $display("reset_mid_ring: state=%0d alarm=%h", state, al_word());
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; alarm_en = 1'b0; set_alarm = 1'b0;
    min_inc = 1'b0; hr_inc = 1'b0; alarm_off = 1'b0; snooze = 1'b0;
    set_time(2'd0, 4'd0, 3'd0, 4'd0, 3'd0, 4'd0);
    test_reset();
    test_setting();
    test_wrap();
    test_trigger();
    test_snooze();
    test_priority();
    test_reset_mid_ring();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_alarm_controller

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Reads the running time-of-day BCD digits produced by the clock counters.
- Holds a user-set alarm time as BCD digits, 24-hour format, HH:MM.
- Runs the alarm state machine: disabled, armed, ringing and snooze.
- Drives the buzzer/LED output and exports the alarm digits so the top level can show them on the existing 7-segment decoders.

Parameters:
- RING_TICKS, 60, number of tick pulses a ring lasts before it stops on its own and returns to ARMED.
- SNOOZE_TICKS, 300, number of tick pulses spent in SNOOZE before ringing again.
- CNT_W, $clog2(max(RING_TICKS,SNOOZE_TICKS)+1), width of the shared tick down-counter.

Ports:
- clk  in  1  system clock; every register uses this one clock.
- reset  in  1  synchronous, active-low reset.
- tick  in  1  one-cycle enable pulse once per clock second; asserted in the same cycle the time counters advance.
- time_h_t  in  2  current hours tens, 0-2.
- time_h_u  in  4  current hours units, 0-9.
- time_m_t  in  3  current minutes tens, 0-5.
- time_m_u  in  4  current minutes units, 0-9.
- time_s_t  in  3  current seconds tens.
- time_s_u  in  4  current seconds units.
- alarm_en  in  1  level; 1 arms the alarm, 0 disables it.
- set_alarm  in  1  level; 1 opens the alarm time for editing.
- min_inc  in  1  single-cycle pulse from the upstream one-shot; adds one minute.
- hr_inc  in  1  single-cycle pulse from the upstream one-shot; adds one hour.
- alarm_off  in  1  single-cycle pulse; silences the alarm.
- snooze  in  1  single-cycle pulse; starts a snooze.
- alarm_out  out  1  buzzer drive.
- alarm_active  out  1  1 while in RINGING or SNOOZE.
- al_h_t  out  2  alarm hours tens digit.
- al_h_u  out  4  alarm hours units digit.
- al_m_t  out  3  alarm minutes tens digit.
- al_m_u  out  4  alarm minutes units digit.
- state  out  2  current FSM state, for debug.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=DISABLED, alarm time=00:00, counter=0.
  - alarm_out=0, alarm_active=0, all al_* digits=0.
- Alarm time editing:
  - Edits take effect only when set_alarm=1; min_inc/hr_inc are ignored otherwise.
  - min_inc: m_u 9->0 carries into m_t; m_t 5->0 wraps with no carry into hours; 59 -> 00.
  - hr_inc: 09->10, 19->20, 23->00.
  - min_inc and hr_inc in the same cycle: both applied.
  - The updated value appears on al_* one cycle after the pulse.
- Match condition:
  - tick=1, state=ARMED, set_alarm=0, and time HH:MM == alarm HH:MM with seconds == 00.
  - Evaluated only on tick cycles, so one alarm minute produces one trigger.
- States and transitions:
  - DISABLED: alarm_en=1 -> ARMED.
  - ARMED: match -> RINGING, counter loaded with RING_TICKS.
  - RINGING:
    - alarm_off -> ARMED.
    - else snooze -> SNOOZE, counter loaded with SNOOZE_TICKS.
    - else each tick decrements the counter; on the tick where the counter=1 -> ARMED.
  - SNOOZE:
    - alarm_off -> ARMED.
    - each tick decrements the counter; on the tick where the counter=1 -> RINGING, counter reloaded with RING_TICKS.
    - snooze pulses while in SNOOZE are ignored.
- Priority of simultaneous events, highest first:
  - alarm_en=0 forces DISABLED from any state.
  - set_alarm=1 while in RINGING or SNOOZE -> ARMED.
  - alarm_off.
  - snooze.
  - tick expiry.
- All transitions take effect on the next clk edge, a latency of 1 cycle.
- alarm_out:
  - 0 in DISABLED, ARMED and SNOOZE.
  - In RINGING it is a beep pattern: set to 1 on entry, toggled on every tick.
  - Forced to 0 on any exit from RINGING.
- alarm_active is registered and equals (state==RINGING || state==SNOOZE).
- Time inputs whose seconds are not 00 never match.
- Out-of-range BCD on the time inputs is compared literally; no correction is applied.

Decomposition:
- Shared package (clock_alarm_pkg):
  - alarm_state_t enum: DISABLED=0, ARMED=1, RINGING=2, SNOOZE=3.
  - Digit width constants: HT_W=2, HU_W=4, MT_W=3, MU_W=4.
  - Digit limits: MAX_H=23, MAX_MT=5.
- One sub-module, alarm_time_register:
  - Holds the four alarm BCD digits.
  - Applies the min_inc/hr_inc wrap rules.
- The FSM and the tick counter live in the top of alarm_controller.

Test Plan:
- Reset and setting: reset=0 for 2 cycles, then set_alarm=1 with 7 hr_inc and 30 min_inc pulses -> al_* reads 07:30, state=DISABLED, alarm_out=0.
- Wrap rules: alarm 23:59, set_alarm=1, one min_inc then one hr_inc -> 23:00, then 00:00; no carry from minutes into hours.
- Trigger and timeout: alarm_en=1, alarm 07:30, time steps 07:29:59 -> 07:30:00 on a tick -> RINGING the next cycle, alarm_out=1 and toggling each tick, ARMED after 60 ticks; no retrigger at 07:30:01.
- Snooze: while RINGING, snooze pulse -> SNOOZE with alarm_out=0; after 300 ticks -> RINGING; then alarm_off -> ARMED with alarm_out=0 the next cycle.
- Priority: alarm_off and snooze in the same cycle while RINGING -> ARMED. alarm_en=0 during SNOOZE -> DISABLED; the match condition then gives no trigger.
- Reset mid-ring: reset=0 while RINGING -> DISABLED, alarm time=00:00 and alarm_out=0 after one edge.
